// File: rtl/gpu_pkg.sv
// Shared types for the warp scheduler slice.
// Warp lifecycle states and retire-kind encodings.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READY    = 2'd1,
        INFLIGHT = 2'd2,
        BARRIER  = 2'd3
    } warp_state_t;

    localparam logic [1:0] CK_NEXT    = 2'b00;
    localparam logic [1:0] CK_BRANCH  = 2'b01;
    localparam logic [1:0] CK_BARRIER = 2'b10;
    localparam logic [1:0] CK_EXIT    = 2'b11;

endpackage

// File: rtl/gpu_rr_picker.sv
// Round-robin first-set finder: scans req starting
// at ptr, wrapping, and grants the first set bit.
module gpu_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_id
);

    logic [W-1:0] idx;

    // Walk offsets 0..N-1 from ptr; first hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + W'(i);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/gpu_warp_scheduler.sv
// Warp scheduler: per-warp PC/state tracking, one
// instruction in flight per warp, RR issue, barriers.
module gpu_warp_scheduler
    import gpu_pkg::*;
#(
    parameter  int NUM_WARPS = 4,
    parameter  int PC_W      = 16,
    localparam int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 launch_valid,
    input  logic [WID_W-1:0]     launch_warp,
    input  logic [PC_W-1:0]      launch_pc,
    output logic                 issue_valid,
    output logic [WID_W-1:0]     issue_warp,
    output logic [PC_W-1:0]      issue_pc,
    input  logic                 issue_ready,
    input  logic                 commit_valid,
    input  logic [WID_W-1:0]     commit_warp,
    input  logic [1:0]           commit_kind,
    input  logic [PC_W-1:0]      commit_target,
    output logic [NUM_WARPS-1:0] active_mask,
    output logic                 all_done,
    output logic                 err
);

    warp_state_t          state [NUM_WARPS];
    logic [PC_W-1:0]      pc    [NUM_WARPS];
    logic [WID_W-1:0]     rr_ptr;
    logic [NUM_WARPS-1:0] ready_mask;
    logic                 grant_valid;
    logic [WID_W-1:0]     grant_id;
    logic                 load;
    logic                 release_all;
    logic                 launch_ok;
    logic                 commit_ok;

    // Candidate and occupancy masks from registered state.
    always_comb begin
        ready_mask  = '0;
        active_mask = '0;
        release_all = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) begin
            ready_mask[w]  = (state[w] == READY);
            active_mask[w] = (state[w] != IDLE);
            if (state[w] != IDLE && state[w] != BARRIER)
                release_all = 1'b0;
        end
        if (active_mask == '0)
            release_all = 1'b0;
    end

    // Launch/commit legality and issue-register load.
    always_comb begin
        load      = !issue_valid || issue_ready;
        commit_ok = commit_valid
                  && (state[commit_warp] == INFLIGHT);
        launch_ok = launch_valid
                  && (state[launch_warp] == IDLE)
                  && !(commit_valid
                       && commit_warp == launch_warp);
    end

    assign all_done = (active_mask == '0) && !issue_valid;

    gpu_rr_picker #(
        .N (NUM_WARPS),
        .W (WID_W)
    ) u_picker (
        .req         (ready_mask),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Warp state, PCs, issue register and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state[w] <= IDLE;
                pc[w]    <= '0;
            end
            issue_valid <= 1'b0;
            issue_warp  <= '0;
            issue_pc    <= '0;
            rr_ptr      <= '0;
            err         <= 1'b0;
        end else begin
            if (release_all) begin
                for (int w = 0; w < NUM_WARPS; w++)
                    if (state[w] == BARRIER)
                        state[w] <= READY;
            end
            if (launch_ok) begin
                state[launch_warp] <= READY;
                pc[launch_warp]    <= launch_pc;
            end else if (launch_valid) begin
                err <= 1'b1;
            end
            if (commit_ok) begin
                unique case (commit_kind)
                    CK_NEXT: begin
                        pc[commit_warp] <=
                            pc[commit_warp] + PC_W'(1);
                        state[commit_warp] <= READY;
                    end
                    CK_BRANCH: begin
                        pc[commit_warp]    <= commit_target;
                        state[commit_warp] <= READY;
                    end
                    CK_BARRIER: begin
                        pc[commit_warp] <=
                            pc[commit_warp] + PC_W'(1);
                        state[commit_warp] <= BARRIER;
                    end
                    CK_EXIT: begin
                        state[commit_warp] <= IDLE;
                    end
                endcase
            end else if (commit_valid) begin
                err <= 1'b1;
            end
            if (load) begin
                issue_valid <= grant_valid;
                if (grant_valid) begin
                    issue_warp      <= grant_id;
                    issue_pc        <= pc[grant_id];
                    state[grant_id] <= INFLIGHT;
                    rr_ptr <= grant_id + WID_W'(1);
                end
            end
        end
    end

endmodule
